// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// divider/counter-width helpers. When UART_RX_PARITY_EN is defined the
// PARITY state exists for the even-parity bit that follows the data bits.
package uart_pkg;

    // Receiver FSM states. PARITY only exists in parity-enabled builds.
    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd4,
`endif
        STOP      = 3'd5
    } rxState_e;

    // Clock cycles per bit, truncated.
    function automatic int unsigned baudDiv(input int unsigned clkHz, input int unsigned baud);
        return clkHz / baud;
    endfunction

    // Half a bit period, used to land the start-bit sample mid-bit.
    function automatic int unsigned halfDiv(input int unsigned div);
        return div / 2;
    endfunction

    // Width of a counter that must reach div-1; never narrower than one bit.
    function automatic int unsigned cntWidth(input int unsigned div);
        int unsigned w;
        w = 1;
        if (div > 1) begin
            w = $clog2(div);
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages load RST_VAL while rstn is low (synchronous, active-low).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic px_clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic metaQ;
    logic syncQ;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            metaQ <= RST_VAL;
            syncQ <= RST_VAL;
        end else begin
            metaQ <= d;
            syncQ <= metaQ;
        end
    end

    assign q = syncQ;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by the pixel clock.
// Build option: UART_RX_PARITY_EN adds an even-parity bit between the data
// bits and the stop bit; without it parity_err is tied low.
module uart_rx #(
    parameter int unsigned CLK_HZ = 31500000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       px_clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] dataRX,
    output logic       WR_RX,
    output logic       frame_err,
    output logic       parity_err
);

    import uart_pkg::*;

    localparam int unsigned DIV   = baudDiv(CLK_HZ, BAUD);
    localparam int unsigned HALF  = halfDiv(DIV);
    localparam int unsigned CNT_W = cntWidth(DIV);

    // Counter values at which the line is sampled.
    localparam logic [CNT_W-1:0] CNT_BIT = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic rxS;

    rxState_e         stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic [2:0]       bitIdxQ, bitIdxD;
    logic [7:0]       shiftQ, shiftD;
    logic [7:0]       dataQ, dataD;
    logic             wrQ, wrD;
    logic             frameErrQ, frameErrD;
    // The synchronizer's reset value is not a real view of the line, so
    // WAIT_IDLE only trusts rxS once both stages have loaded the line.
    logic [1:0]       primeQ, primeD;
`ifdef UART_RX_PARITY_EN
    logic             parityBadQ, parityBadD;
    logic             parityErrQ, parityErrD;
`endif

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) uSync (
        .px_clk (px_clk),
        .rstn   (rstn),
        .d      (rx),
        .q      (rxS)
    );

    // Next-state, datapath and strobe decode; strobes default low every cycle.
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        bitIdxD   = bitIdxQ;
        shiftD    = shiftQ;
        dataD     = dataQ;
        wrD       = 1'b0;
        frameErrD = 1'b0;
        primeD    = {primeQ[0], 1'b1};
`ifdef UART_RX_PARITY_EN
        parityBadD = parityBadQ;
        parityErrD = 1'b0;
`endif

        unique case (stateQ)
            WAIT_IDLE: begin
                if (rxS && primeQ[1]) begin
                    stateD = IDLE;
                end
            end

            IDLE: begin
                if (!rxS) begin
                    stateD = START;
                    cntD   = '0;
                end
            end

            START: begin
                if (cntQ == CNT_MID) begin
                    cntD    = '0;
                    bitIdxD = '0;
                    // A line back high at mid start bit is a glitch.
                    stateD  = rxS ? IDLE : DATA;
                end else begin
                    cntD = cntQ + CNT_ONE;
                end
            end

            DATA: begin
                if (cntQ == CNT_BIT) begin
                    cntD    = '0;
                    shiftD  = {rxS, shiftQ[7:1]};
                    bitIdxD = bitIdxQ + 3'd1;
                    if (bitIdxQ == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        stateD = PARITY;
`else
                        stateD = STOP;
`endif
                    end
                end else begin
                    cntD = cntQ + CNT_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cntQ == CNT_BIT) begin
                    cntD       = '0;
                    // Even parity: data plus parity bit must have an even count of ones.
                    parityBadD = ^{shiftQ, rxS};
                    stateD     = STOP;
                end else begin
                    cntD = cntQ + CNT_ONE;
                end
            end
`endif

            STOP: begin
                if (cntQ == CNT_BIT) begin
                    cntD = '0;
                    if (rxS) begin
                        stateD = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parityBadQ) begin
                            parityErrD = 1'b1;
                        end else begin
                            wrD   = 1'b1;
                            dataD = shiftQ;
                        end
`else
                        wrD   = 1'b1;
                        dataD = shiftQ;
`endif
                    end else begin
                        // Line may stay in break; wait for it to return high.
                        frameErrD = 1'b1;
                        stateD    = WAIT_IDLE;
                    end
                end else begin
                    cntD = cntQ + CNT_ONE;
                end
            end

            default: begin
                stateD = WAIT_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            stateQ    <= WAIT_IDLE;
            cntQ      <= '0;
            bitIdxQ   <= '0;
            shiftQ    <= '0;
            primeQ    <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            bitIdxQ   <= bitIdxD;
            shiftQ    <= shiftD;
            primeQ    <= primeD;
        end
    end

    // Registered outputs: byte and strobes appear the cycle after the stop sample.
    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            dataQ     <= '0;
            wrQ       <= 1'b0;
            frameErrQ <= 1'b0;
        end else begin
            dataQ     <= dataD;
            wrQ       <= wrD;
            frameErrQ <= frameErrD;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict for the current frame and its error strobe.
    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            parityBadQ <= 1'b0;
            parityErrQ <= 1'b0;
        end else begin
            parityBadQ <= parityBadD;
            parityErrQ <= parityErrD;
        end
    end

    assign parity_err = parityErrQ;
`else
    assign parity_err = 1'b0;
`endif

    assign dataRX    = dataQ;
    assign WR_RX     = wrQ;
    assign frame_err = frameErrQ;

    // At most one strobe per cycle.
    strobesExclusive: assert property (@(posedge px_clk) disable iff (!rstn)
        $onehot0({WR_RX, frame_err, parity_err}));

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are built bit by bit from the byte
// value; the expected results come from a byte-level model (queue of bytes
// that should arrive, count of expected error strobes, last good byte).
module tb_uart_rx;

    localparam int unsigned CLK_HZ = 31500000;
    localparam int unsigned BAUD   = 115200;
    localparam int DIV  = 273;
    localparam int HALF = 136;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Middle of the stop bit, measured from the start-bit falling edge.
    localparam longint STOP_MID = longint'((FRAME_BITS - 1) * DIV + HALF);
    localparam longint SLACK    = 6;

    logic       px_clk = 1'b0;
    logic       rstn   = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] dataRX;
    logic       WR_RX;
    logic       frame_err;
    logic       parity_err;

`ifdef UART_RX_PARITY_EN
    logic badParity = 1'b0;
`endif

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .px_clk     (px_clk),
        .rstn       (rstn),
        .rx         (rx),
        .dataRX     (dataRX),
        .WR_RX      (WR_RX),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 px_clk = ~px_clk;

    longint cyc = 0;
    always @(posedge px_clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    logic [7:0] wrData[$];
    longint     wrCyc[$];
    int         feCnt = 0;
    int         peCnt = 0;
    int         multiCnt = 0;
    always @(negedge px_clk) begin
        if (WR_RX === 1'b1) begin
            wrData.push_back(dataRX);
            wrCyc.push_back(cyc);
        end
        if (frame_err === 1'b1) feCnt++;
        if (parity_err === 1'b1) peCnt++;
        if ((int'(WR_RX) + int'(frame_err) + int'(parity_err)) > 1) multiCnt++;
    end

    int nCmp = 0;
    int nBad = 0;
    logic [7:0] lastGood = 8'h00;

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge px_clk);
    endtask

    task automatic idle(input int n);
        hold(1'b1, n);
    endtask

    // Serialise one frame; edgeCyc is the cycle of the start-bit falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stopBit, output longint edgeCyc);
        edgeCyc = cyc;
        hold(1'b0, DIV);
        for (int i = 0; i < 8; i++) hold(b[i], DIV);
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ badParity, DIV);
`endif
        hold(stopBit, DIV);
    endtask

    task automatic test_reset();
        int wr0, fe0;
        rx = 1'b0;
        rstn = 1'b0;
        repeat (5) @(negedge px_clk);
        nCmp++; if (dataRX !== 8'h00) begin nBad++; $display("FAIL reset_data: got %h expected 00", dataRX); end
        nCmp++; if (WR_RX !== 1'b0) begin nBad++; $display("FAIL reset_wr: got %b expected 0", WR_RX); end
        nCmp++; if (frame_err !== 1'b0) begin nBad++; $display("FAIL reset_fe: got %b expected 0", frame_err); end
        nCmp++; if (parity_err !== 1'b0) begin nBad++; $display("FAIL reset_pe: got %b expected 0", parity_err); end
        wr0 = wrData.size();
        fe0 = feCnt;
        rstn = 1'b1;
        // Line held low for longer than a whole frame after release.
        hold(1'b0, 12 * DIV);
        nCmp++; if (wrData.size() - wr0 !== 0) begin nBad++; $display("FAIL low_after_reset_wr: got %0d expected 0", wrData.size() - wr0); end
        nCmp++; if (feCnt - fe0 !== 0) begin nBad++; $display("FAIL low_after_reset_fe: got %0d expected 0", feCnt - fe0); end
        idle(2 * DIV);
    endtask

    task automatic test_single();
        int wr0, fe0;
        longint e, lat;
        logic [7:0] got;
        wr0 = wrData.size();
        fe0 = feCnt;
        send_frame(8'h41, 1'b1, e);
        idle(DIV);
        got = 'x;
        lat = -1;
        if (wrData.size() > wr0) begin got = wrData[wr0]; lat = wrCyc[wr0] - e; end
        nCmp++; if (wrData.size() - wr0 !== 1) begin nBad++; $display("FAIL single_count: got %0d expected 1", wrData.size() - wr0); end
        nCmp++; if (got !== 8'h41) begin nBad++; $display("FAIL single_byte: got %h expected 41", got); end
        nCmp++; if (dataRX !== 8'h41) begin nBad++; $display("FAIL single_hold: got %h expected 41", dataRX); end
        nCmp++; if (feCnt - fe0 !== 0) begin nBad++; $display("FAIL single_fe: got %0d expected 0", feCnt - fe0); end
        nCmp++; if (lat < STOP_MID || lat > STOP_MID + SLACK) begin
            nBad++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, STOP_MID, STOP_MID + SLACK);
        end
        lastGood = 8'h41;
    endtask

    task automatic test_back_to_back();
        int wr0;
        longint e0, e1, gap;
        logic [7:0] g0, g1;
        wr0 = wrData.size();
        send_frame(8'h43, 1'b1, e0);
        send_frame(8'h44, 1'b1, e1);
        idle(2 * DIV);
        g0 = 'x; g1 = 'x; gap = -1;
        if (wrData.size() > wr0 + 1) begin
            g0 = wrData[wr0]; g1 = wrData[wr0 + 1]; gap = wrCyc[wr0 + 1] - wrCyc[wr0];
        end
        nCmp++; if (wrData.size() - wr0 !== 2) begin nBad++; $display("FAIL b2b_count: got %0d expected 2", wrData.size() - wr0); end
        nCmp++; if (g0 !== 8'h43) begin nBad++; $display("FAIL b2b_first: got %h expected 43", g0); end
        nCmp++; if (g1 !== 8'h44) begin nBad++; $display("FAIL b2b_second: got %h expected 44", g1); end
        nCmp++; if (gap !== longint'(FRAME_BITS * DIV)) begin
            nBad++; $display("FAIL b2b_spacing: got %0d expected %0d", gap, FRAME_BITS * DIV);
        end
        nCmp++; if (dataRX !== 8'h44) begin nBad++; $display("FAIL b2b_hold: got %h expected 44", dataRX); end
        lastGood = 8'h44;
    endtask

    task automatic test_glitch();
        int wr0, fe0;
        longint e;
        logic [7:0] got;
        wr0 = wrData.size();
        fe0 = feCnt;
        hold(1'b0, 100);
        idle(2 * DIV);
        nCmp++; if (wrData.size() - wr0 !== 0) begin nBad++; $display("FAIL glitch_wr: got %0d expected 0", wrData.size() - wr0); end
        nCmp++; if (feCnt - fe0 !== 0) begin nBad++; $display("FAIL glitch_fe: got %0d expected 0", feCnt - fe0); end
        send_frame(8'h42, 1'b1, e);
        idle(DIV);
        got = 'x;
        if (wrData.size() > wr0) got = wrData[wr0];
        nCmp++; if (got !== 8'h42) begin nBad++; $display("FAIL glitch_next: got %h expected 42", got); end
        lastGood = 8'h42;
    endtask

    task automatic test_frame_err();
        int wr0, fe0;
        longint e;
        logic [7:0] got;
        wr0 = wrData.size();
        fe0 = feCnt;
        send_frame(8'h55, 1'b0, e);
        hold(1'b0, 1000);
        nCmp++; if (feCnt - fe0 !== 1) begin nBad++; $display("FAIL ferr_count: got %0d expected 1", feCnt - fe0); end
        nCmp++; if (wrData.size() - wr0 !== 0) begin nBad++; $display("FAIL ferr_wr: got %0d expected 0", wrData.size() - wr0); end
        nCmp++; if (dataRX !== lastGood) begin nBad++; $display("FAIL ferr_hold: got %h expected %h", dataRX, lastGood); end
        idle(2 * DIV);
        send_frame(8'h41, 1'b1, e);
        idle(DIV);
        got = 'x;
        if (wrData.size() > wr0) got = wrData[wr0];
        nCmp++; if (got !== 8'h41) begin nBad++; $display("FAIL ferr_recover: got %h expected 41", got); end
        nCmp++; if (feCnt - fe0 !== 1) begin nBad++; $display("FAIL ferr_once: got %0d expected 1", feCnt - fe0); end
        lastGood = 8'h41;
    endtask

    task automatic test_reset_midframe();
        int wr0, fe0, pe0;
        longint e;
        logic [7:0] b, got;
        b = 8'h44;
        wr0 = wrData.size();
        fe0 = feCnt;
        pe0 = peCnt;
        hold(1'b0, DIV);
        for (int i = 0; i < 4; i++) hold(b[i], DIV);
        hold(b[4], DIV / 2);
        rstn = 1'b0;
        hold(1'b0, 10);
        rstn = 1'b1;
        hold(1'b0, DIV);
        idle(3 * DIV);
        lastGood = 8'h00;
        nCmp++; if (wrData.size() - wr0 !== 0) begin nBad++; $display("FAIL rstmid_wr: got %0d expected 0", wrData.size() - wr0); end
        nCmp++; if (feCnt - fe0 !== 0) begin nBad++; $display("FAIL rstmid_fe: got %0d expected 0", feCnt - fe0); end
        nCmp++; if (peCnt - pe0 !== 0) begin nBad++; $display("FAIL rstmid_pe: got %0d expected 0", peCnt - pe0); end
        nCmp++; if (dataRX !== 8'h00) begin nBad++; $display("FAIL rstmid_data: got %h expected 00", dataRX); end
        send_frame(8'h41, 1'b1, e);
        idle(DIV);
        got = 'x;
        if (wrData.size() > wr0) got = wrData[wr0];
        nCmp++; if (got !== 8'h41) begin nBad++; $display("FAIL rstmid_next: got %h expected 41", got); end
        lastGood = 8'h41;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int wr0, pe0;
        longint e;
        logic [7:0] got;
        wr0 = wrData.size();
        pe0 = peCnt;
        badParity = 1'b1;
        send_frame(8'h41, 1'b1, e);
        badParity = 1'b0;
        idle(DIV);
        nCmp++; if (peCnt - pe0 !== 1) begin nBad++; $display("FAIL par_count: got %0d expected 1", peCnt - pe0); end
        nCmp++; if (wrData.size() - wr0 !== 0) begin nBad++; $display("FAIL par_wr: got %0d expected 0", wrData.size() - wr0); end
        nCmp++; if (dataRX !== lastGood) begin nBad++; $display("FAIL par_hold: got %h expected %h", dataRX, lastGood); end
        send_frame(8'h5a, 1'b1, e);
        idle(DIV);
        got = 'x;
        if (wrData.size() > wr0) got = wrData[wr0];
        nCmp++; if (got !== 8'h5a) begin nBad++; $display("FAIL par_next: got %h expected 5a", got); end
        lastGood = 8'h5a;
    endtask
`endif

    task automatic test_random();
        int wr0, fe0, expFe, gap;
        longint e;
        logic [7:0] b, got;
        logic stopOk;
        logic [7:0] expQ[$];
        wr0 = wrData.size();
        fe0 = feCnt;
        expFe = 0;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            stopOk = ($urandom_range(0, 4) != 0);
            send_frame(b, stopOk, e);
            if (stopOk) begin
                expQ.push_back(b);
                lastGood = b;
                gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
            end else begin
                expFe++;
                gap = DIV + int'($urandom_range(0, 60));
            end
            if (gap > 0) idle(gap);
        end
        idle(DIV);
        nCmp++; if (wrData.size() - wr0 !== expQ.size()) begin
            nBad++; $display("FAIL rand_count: got %0d expected %0d", wrData.size() - wr0, expQ.size());
        end
        for (int i = 0; i < expQ.size(); i++) begin
            got = 'x;
            if (wrData.size() > wr0 + i) got = wrData[wr0 + i];
            nCmp++; if (got !== expQ[i]) begin nBad++; $display("FAIL rand_byte%0d: got %h expected %h", i, got, expQ[i]); end
        end
        nCmp++; if (feCnt - fe0 !== expFe) begin nBad++; $display("FAIL rand_fe: got %0d expected %0d", feCnt - fe0, expFe); end
        nCmp++; if (dataRX !== lastGood) begin nBad++; $display("FAIL rand_hold: got %h expected %h", dataRX, lastGood); end
        nCmp++; if (multiCnt !== 0) begin nBad++; $display("FAIL strobe_overlap: got %0d expected 0", multiCnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 31500000, px_clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 px_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-006 dataRX  output  8  last correctly received byte.
REQ-007 WR_RX  output  1  one-cycle strobe; dataRX is valid and already updated in the same cycle.
REQ-008 frame_err  output  1  one-cycle strobe on bad stop bit.
REQ-009 parity_err  output  1  one-cycle strobe on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s); both flops reset to 1.
REQ-011 DIV = CLK_HZ/BAUD (integer, truncated); HALF = DIV/2; the bit counter is $clog2(DIV) bits wide.
REQ-012 FSM states: WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
REQ-013 WAIT_IDLE SHALL go to IDLE on the first cycle with rx_s==1.
REQ-014 IDLE SHALL go to START with the counter cleared on rx_s==0.
REQ-015 START SHALL sample rx_s when the counter reaches HALF-1: 0 -> DATA (counter and bit index cleared); 1 -> IDLE (glitch rejected, no strobe).
REQ-016 DATA SHALL sample rx_s each time the counter reaches DIV-1; sampled bits shift in from the MSB side (LSB first); after bit index 7 go to PARITY (if enabled), else to STOP.
REQ-017 STOP SHALL sample at DIV-1: 1 -> dataRX takes the shift register and WR_RX=1 on the next cycle, then IDLE; 0 -> frame_err=1 on the next cycle, dataRX unchanged, then WAIT_IDLE.
REQ-018 WR_RX, frame_err and parity_err SHALL each be high for exactly one cycle per frame and are mutually exclusive.
REQ-019 dataRX SHALL hold its value between strobes.
REQ-020 A new start bit accepted in the IDLE cycle immediately after WR_RX SHALL be received normally (back-to-back frames, no dead time).

Reset
REQ-021 On rstn==0: state=WAIT_IDLE, dataRX=0, WR_RX=0, frame_err=0, parity_err=0, counters=0, synchronizer=1.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte and produce no strobe.
REQ-023 A line still low after reset release SHALL NOT be taken as a start bit (enforced by WAIT_IDLE).

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: an even-parity bit follows the data bits; PARITY samples at DIV-1 and goes to STOP; on mismatch, a good stop bit gives parity_err=1 instead of WR_RX, and dataRX stays unchanged.
REQ-025 Macro UART_RX_PARITY_EN undefined: the PARITY state and its logic are absent; parity_err is tied to 0.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum and the DIV/HALF width function.
REQ-027 Sub-module uart_sync2 SHALL implement the 2-flop synchronizer with reset value parameter RST_VAL=1.

Verification (CLK_HZ=31500000, BAUD=115200, DIV=273, HALF=136)
REQ-028 Send 0x41 ('A') at 273 cycles/bit -> one WR_RX pulse, dataRX=0x41, frame_err=0, WR_RX 1 cycle after the stop-bit sample.
REQ-029 Send 0x43, 0x44 back-to-back with no idle gap -> two WR_RX pulses 2730 cycles apart, dataRX 0x43 then 0x44.
REQ-030 rx low for 100 cycles, then high -> no strobe; state returns to IDLE; a following 0x42 is received correctly.
REQ-031 Send 0x55 with the stop bit held 0, then the line stays low 1000 cycles -> frame_err pulse once, dataRX unchanged, no WR_RX until rx rises and a new 0x41 arrives.
REQ-032 Assert rstn low during bit 4 of 0x44 with rx low at release -> no strobe, dataRX=0, next full 0x41 received.
REQ-033 With UART_RX_PARITY_EN, send 0x41 with parity bit 1 (wrong; even parity is 0) -> parity_err pulse, no WR_RX, dataRX unchanged.
